// File: rtl/mest_pro_prog_mem_pkg.sv
// Shared definitions for the MESTPro program memory: loader FSM encoding,
// the NOP fill value and the default instruction width.
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif

package mest_pro_prog_mem_pkg;

    localparam int INSTR_SIZE_DEFAULT = `INSTRUCTION_SIZE;

    // A NOP is an all-zero instruction word.
    localparam logic NOP_FILL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mest_pro_prog_mem_array.sv
// Instruction storage: synchronous write, asynchronous read. Kept apart from the
// loader so it can later be replaced by an SRAM macro.
module mest_pro_prog_mem_array
    import mest_pro_prog_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = INSTR_SIZE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mest_pro_prog_mem.sv
// MESTPro program memory: combinational fetch port plus a byte-wide host loader.
//   state   | meaning
//   IDLE    | serving fetches, waiting for i_load_start
//   LOAD    | accepting loader beats, assembling and writing words
//   DONE    | one-cycle o_load_done pulse, then back to IDLE
module mest_pro_prog_mem
    import mest_pro_prog_mem_pkg::*;
#(
    parameter int INSTRUCTION_SIZE = INSTR_SIZE_DEFAULT,
    parameter int ROM_DEPTH        = 256,
    parameter int LOAD_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_req,
    input  logic [$clog2(ROM_DEPTH)-1:0] i_prog_counter,
    output logic [INSTRUCTION_SIZE-1:0]  o_instruction,
    output logic                         o_ready,
    output logic                         o_fetch_err,
    input  logic                         i_load_start,
    input  logic [$clog2(ROM_DEPTH)-1:0] i_load_base,
    input  logic                         i_load_valid,
    input  logic [LOAD_WIDTH-1:0]        i_load_data,
    input  logic                         i_load_last,
    output logic                         o_load_ready,
    output logic                         o_load_done,
    output logic                         o_load_err
);

    localparam int AW  = $clog2(ROM_DEPTH);
    localparam int BPW = (INSTRUCTION_SIZE + LOAD_WIDTH - 1) / LOAD_WIDTH;
    localparam int SHW = BPW * LOAD_WIDTH;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BPW - 1);
    localparam logic [AW-1:0]  TOP_ADDR  = AW'(ROM_DEPTH - 1);

    state_e                      r_state;
    state_e                      w_state_next;
    logic [BCW-1:0]              r_beat_cnt;
    logic [AW-1:0]               r_addr;
    logic [SHW-1:0]              r_shreg;
    logic                        r_ovf;
    logic                        r_fetch_err;
    logic                        r_load_err;
    logic                        w_beat;
    logic                        w_word_end;
    logic                        w_we;
    logic [SHW-1:0]              w_shreg_next;
    logic [SHW-1:0]              w_word_aligned;
    logic [INSTRUCTION_SIZE-1:0] w_wdata;
    logic [INSTRUCTION_SIZE-1:0] w_rdata;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_load_ready = 1'b0;
        o_load_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_load_start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_load_ready = 1'b1;
                if (w_beat && i_load_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_load_done  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_beat       = (r_state == ST_LOAD) && i_load_valid;
    assign w_word_end   = w_beat && ((r_beat_cnt == LAST_BEAT) || i_load_last);
    assign w_we         = w_word_end && !r_ovf;
    assign w_shreg_next = (r_shreg << LOAD_WIDTH) | SHW'(i_load_data);
    // A short final word is left-justified, leaving zeros in the missing beats.
    assign w_word_aligned = w_shreg_next << (int'(LAST_BEAT - r_beat_cnt) * LOAD_WIDTH);
    assign w_wdata        = w_word_aligned[SHW-1 -: INSTRUCTION_SIZE];

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_beat_cnt  <= '0;
            r_addr      <= '0;
            r_shreg     <= '0;
            r_ovf       <= 1'b0;
            r_fetch_err <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            if (i_req && !o_ready) r_fetch_err <= 1'b1;
            if ((r_state == ST_IDLE) && i_load_start) begin
                r_addr     <= i_load_base;
                r_beat_cnt <= '0;
                r_shreg    <= '0;
                r_ovf      <= 1'b0;
                r_load_err <= 1'b0;
            end else if (w_beat) begin
                if (w_word_end) begin
                    r_beat_cnt <= '0;
                    r_shreg    <= '0;
                    // Once the top word is written, further words are dropped, not wrapped.
                    if (r_ovf) begin
                        r_load_err <= 1'b1;
                    end else if (r_addr == TOP_ADDR) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    r_shreg    <= w_shreg_next;
                end
            end
        end
    end

    mest_pro_prog_mem_array #(
        .DEPTH (ROM_DEPTH),
        .WIDTH (INSTRUCTION_SIZE)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_wdata),
        .i_raddr (i_prog_counter),
        .o_rdata (w_rdata)
    );

    assign o_instruction = (o_ready && i_req) ? w_rdata : {INSTRUCTION_SIZE{NOP_FILL}};
    assign o_fetch_err   = r_fetch_err;
    assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_mest_pro_prog_mem.sv
// Self-checking bench for mest_pro_prog_mem (16-bit words, 8-bit beats, 256 words).
module tb_mest_pro_prog_mem;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req = 1'b0;
    logic [7:0]  i_prog_counter = '0;
    logic [15:0] o_instruction;
    logic        o_ready;
    logic        o_fetch_err;
    logic        i_load_start = 1'b0;
    logic [7:0]  i_load_base = '0;
    logic        i_load_valid = 1'b0;
    logic [7:0]  i_load_data = '0;
    logic        i_load_last = 1'b0;
    logic        o_load_ready;
    logic        o_load_done;
    logic        o_load_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        req;
        logic [7:0]  pc;
        logic [15:0] exp_instr;
    } fetch_vec_t;

    fetch_vec_t vecs[10];

    mest_pro_prog_mem #(
        .INSTRUCTION_SIZE (16),
        .ROM_DEPTH        (256),
        .LOAD_WIDTH       (8)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_prog_counter (i_prog_counter),
        .o_instruction  (o_instruction),
        .o_ready        (o_ready),
        .o_fetch_err    (o_fetch_err),
        .i_load_start   (i_load_start),
        .i_load_base    (i_load_base),
        .i_load_valid   (i_load_valid),
        .i_load_data    (i_load_data),
        .i_load_last    (i_load_last),
        .o_load_ready   (o_load_ready),
        .o_load_done    (o_load_done),
        .o_load_err     (o_load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Drive a fetch, queue its expected word, then compare once it settles.
    task automatic fetch(input string nm, input logic req, input logic [7:0] pc, input logic [15:0] exp);
        logic [15:0] e;
        i_req          = req;
        i_prog_counter = pc;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check(nm, o_instruction, e);
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        i_load_valid = 1'b1;
        i_load_data  = d;
        i_load_last  = last;
        tick();
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
    endtask

    task automatic start(input logic [7:0] base, input bit with_req);
        i_load_base  = base;
        i_load_start = 1'b1;
        if (with_req) fetch("fetch_on_start", 1'b1, 8'd0, 16'h1234);
        tick();
        i_load_start = 1'b0;
        i_req        = 1'b0;
        #1;
        check("load_ready_in_load", o_load_ready, 1);
        check("ready_low_in_load", o_ready, 0);
    endtask

    task automatic finish_session(input string nm);
        check({nm, "_done_pulse"}, o_load_done, 1);
        check({nm, "_ready_in_done"}, o_ready, 0);
        tick();
        check({nm, "_done_one_cycle"}, o_load_done, 0);
        check({nm, "_ready_after"}, o_ready, 1);
    endtask

    task automatic session(input string nm, input logic [7:0] base, input logic [7:0] b[4],
                           input int n, input int gap);
        start(base, 1'b0);
        for (int i = 0; i < n; i++) begin
            beat(b[i], i == n - 1);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (g == 1) begin
                        i_load_base  = 8'd30;
                        i_load_start = 1'b1;
                    end
                    tick();
                    i_load_start = 1'b0;
                end
            end
        end
        finish_session(nm);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd0,   16'h1234};
        vecs[1] = '{1'b1, 8'd1,   16'h5678};
        vecs[2] = '{1'b1, 8'd5,   16'hAABB};
        vecs[3] = '{1'b1, 8'd6,   16'hCC00};
        vecs[4] = '{1'b1, 8'd20,  16'h1234};
        vecs[5] = '{1'b1, 8'd21,  16'h5678};
        vecs[6] = '{1'b1, 8'd255, 16'h9ABC};
        vecs[7] = '{1'b1, 8'd10,  16'hA55A};
        vecs[8] = '{1'b1, 8'd11,  16'h2222};
        vecs[9] = '{1'b0, 8'd1,   16'h0000};

        tick();
        tick();
        i_reset = 1'b0;
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_load_ready", o_load_ready, 0);
        check("rst_load_done", o_load_done, 0);
        check("rst_fetch_err", o_fetch_err, 0);
        check("rst_load_err", o_load_err, 0);

        session("s0", 8'd0, '{8'h12, 8'h34, 8'h56, 8'h78}, 4, 0);
        fetch("pc1_after_load", 1'b1, 8'd1, 16'h5678);
        fetch("pc0_after_load", 1'b1, 8'd0, 16'h1234);
        i_req = 1'b0;

        session("s5", 8'd5, '{8'hAA, 8'hBB, 8'hCC, 8'h00}, 3, 0);

        // Gapped beats, a stray start mid-session, and a fetch coincident with start.
        start(8'd20, 1'b1);
        begin
            logic [7:0] g[4];
            g = '{8'h12, 8'h34, 8'h56, 8'h78};
            for (int i = 0; i < 4; i++) begin
                beat(g[i], i == 3);
                if (i < 3) begin
                    for (int k = 0; k < 3; k++) begin
                        if (k == 1) begin
                            i_load_base  = 8'd30;
                            i_load_start = 1'b1;
                        end
                        tick();
                        i_load_start = 1'b0;
                        if (k == 1) check("stray_start_ignored", o_load_ready, 1);
                    end
                end
            end
        end
        finish_session("gap");
        check("no_fetch_err_after_gap", o_fetch_err, 0);

        session("ovf", 8'd255, '{8'h9A, 8'hBC, 8'hDE, 8'hF0}, 4, 0);
        check("ovf_load_err", o_load_err, 1);
        fetch("ovf_mem0_kept", 1'b1, 8'd0, 16'h1234);
        i_req = 1'b0;

        // Fetch while loading: NOP returned and a sticky error raised.
        start(8'd10, 1'b0);
        check("start_clears_load_err", o_load_err, 0);
        fetch("fetch_in_load_nop", 1'b1, 8'd1, 16'h0000);
        beat(8'h11, 1'b0);
        i_req = 1'b0;
        check("fetch_err_set", o_fetch_err, 1);
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h22, 1'b1);
        finish_session("pre");
        tick();
        check("fetch_err_sticky", o_fetch_err, 1);

        // Reset after the third beat of a four-beat load.
        start(8'd10, 1'b0);
        beat(8'hA5, 1'b0);
        beat(8'h5A, 1'b0);
        beat(8'hC3, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("rst_mid_ready", o_ready, 1);
        check("rst_mid_load_ready", o_load_ready, 0);
        check("rst_mid_fetch_err", o_fetch_err, 0);
        check("rst_mid_done", o_load_done, 0);
        tick();
        check("rst_mid_ready_next", o_ready, 1);

        for (int i = 0; i < 10; i++) begin
            fetch($sformatf("vec%0d_pc%0d", i, vecs[i].pc), vecs[i].req, vecs[i].pc, vecs[i].exp_instr);
        end
        i_req = 1'b0;
        tick();
        check("final_fetch_err", o_fetch_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mest_pro_prog_mem.md
Name: mest_pro_prog_mem

Overview:
- Program-memory responder on the far end of the MESTPro fetch interface.
- Serves instruction words combinationally to the fetch stage. The fetcher samples the instruction on the same edge that it advances the program counter, so the read must be valid in the request cycle.
- Provides a byte-wide loader FSM so a host can write a program image before the core leaves idle.
- Sits between the host/debug loader and mest_pro_fetch.

Parameters:
- INSTRUCTION_SIZE, default `INSTRUCTION_SIZE, width of one instruction word.
- ROM_DEPTH, default 256, number of instruction words.
- LOAD_WIDTH, default 8, width of one loader beat.
- BPW (localparam) = ceil(INSTRUCTION_SIZE/LOAD_WIDTH), beats per word.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request, driven from the fetch stage's o_req.
- i_prog_counter  input  $clog2(ROM_DEPTH)  fetch word address.
- o_instruction  output  INSTRUCTION_SIZE  fetched word, combinational.
- o_ready  output  1  high when the memory serves fetches (FSM in IDLE).
- o_fetch_err  output  1  sticky; set when a fetch arrives while not ready.
- i_load_start  input  1  pulse; begins a load session.
- i_load_base  input  $clog2(ROM_DEPTH)  first word address of the session.
- i_load_valid  input  1  loader beat valid.
- i_load_data  input  LOAD_WIDTH  loader beat, MSB-first within a word.
- i_load_last  input  1  qualifies the final beat of the session.
- o_load_ready  output  1  beat accepted when i_load_valid & o_load_ready.
- o_load_done  output  1  one-cycle pulse at the end of a session.
- o_load_err  output  1  sticky; set on address overflow.

Behaviour:
- Reset (i_reset=1 at an edge):
  - FSM goes to IDLE; beat counter, address counter and shift register are cleared.
  - o_fetch_err=0, o_load_err=0, o_load_done=0.
  - Memory array is not reset.
  - Reset mid-load aborts the session: the partial word is discarded and already-written words are retained.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: o_ready=1, o_load_ready=0. On i_load_start go to LOAD, set addr=i_load_base, beat_cnt=0, and clear o_load_err.
  - LOAD: o_ready=0, o_load_ready=1. Each accepted beat does shreg={shreg, data} and beat_cnt++.
    - On the BPW-th beat, write the assembled word to mem[addr] in that same edge, then addr++ and beat_cnt=0.
    - On an accepted beat with i_load_last: write the word, left-justified and zero-padded in the LSBs if fewer than BPW beats arrived, then go to DONE.
    - If last completes the word exactly, only one write occurs.
  - DONE: o_load_done=1 for exactly one cycle, then IDLE. o_ready=0 in DONE.
- i_load_start outside IDLE is ignored. i_load_valid outside LOAD is ignored.
- Overflow: a word write targeting addr after the word at ROM_DEPTH-1 has been written is suppressed.
  - o_load_err is set, and no wrap-around write occurs.
  - The session still ends normally on last.
  - An overflow flag register tracks the condition; addr does not wrap.
- Fetch:
  - o_instruction = mem[i_prog_counter] when o_ready & i_req, else 0 (NOP).
  - i_req while o_ready=0 sets o_fetch_err (sticky until reset); no stall is generated.
- Latency: zero-cycle combinational read. A loaded word is visible to fetch from the cycle after its write edge.
- Simultaneous i_load_start and i_req in IDLE: that cycle's fetch is served, and the FSM enters LOAD at the edge.

Decomposition:
- Shared package/param.vh holds:
  - the FSM state encoding (IDLE/LOAD/DONE);
  - the NOP encoding (all zeros);
  - reuse of `INSTRUCTION_SIZE.
- Sub-module mest_pro_prog_mem_array: ROM_DEPTH x INSTRUCTION_SIZE array with synchronous write and asynchronous read. Keeps the loader FSM and the storage separable for a future SRAM macro swap.

Test Plan:
- Load base=0, INSTRUCTION_SIZE=16, beats 12,34,56,78 with last on 78 -> mem[0]=0x1234, mem[1]=0x5678, o_load_done pulses once 1 cycle after last; then i_req with pc=1 -> o_instruction=0x5678 combinationally.
- Load base=5, three beats AA,BB,CC with last on CC -> mem[5]=0xAABB, mem[6]=0xCC00 (padded), addr stops at 7.
- Load base=255, four beats -> mem[255] written, second word suppressed, o_load_err=1, o_load_done still pulses, mem[0] unchanged.
- i_req=1 during LOAD -> o_instruction=0, o_fetch_err=1 and stays 1 after the load completes, until i_reset.
- i_reset asserted after the third beat of a 4-beat load at base 10 -> mem[10] holds the new word, mem[11] keeps its old value, FSM in IDLE, o_ready=1 on the next cycle.
- i_load_valid stall gaps (valid low for 3 cycles between beats) and i_load_start pulsed during LOAD -> the assembled words are identical to the gap-free case and the session is not restarted.
